// File: rtl/ibis_tile_sequencer_if.sv
// Mapper-side and output-stream signals of the tile sequencer.
// master = sequencer, slave = mapper/stream-consumer side.
interface ibis_tile_sequencer_if #(
  parameter int WIDTH = 10
);
  logic             map_enable;
  logic [WIDTH-1:0] map_x;
  logic [WIDTH-1:0] map_y;
  logic             map_cycle_complete;
  logic [8:0]       map_data;
  logic             m_valid;
  logic             m_ready;
  logic [8:0]       m_data;
  logic [WIDTH-1:0] m_x;
  logic [WIDTH-1:0] m_y;
  logic             m_last;

  modport master (
    output map_enable, map_x, map_y,
    input  map_cycle_complete, map_data,
    output m_valid, m_data, m_x, m_y, m_last,
    input  m_ready
  );

  modport slave (
    input  map_enable, map_x, map_y,
    output map_cycle_complete, map_data,
    input  m_valid, m_data, m_x, m_y, m_last,
    output m_ready
  );
endinterface

// File: rtl/ibis_tile_sequencer.sv
// Walks one 2^P x 2^P tile in raster order, feeding a 10-stage mapper ring and streaming texels.
// Optional stall counter enabled by defining IBIS_TILE_SEQUENCER_PERF_EN.
module ibis_tile_sequencer #(
  parameter int TILE_SIZE_POW2 = 5,
  parameter int WIDTH          = 10
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [WIDTH-1:0] origin_x,
  input  logic [WIDTH-1:0] origin_y,
  output logic             busy,
  output logic             done,
`ifdef IBIS_TILE_SEQUENCER_PERF_EN
  output logic [31:0]      perf_stall_cycles,
`endif
  ibis_tile_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, MAP, CAPTURE, OUT, DONE} state_e;

  state_e                    state_q, state_d;
  logic [TILE_SIZE_POW2-1:0] col_q, row_q;
  logic [WIDTH-1:0]          originX_q, originY_q;
  logic [8:0]                mData_q;
  logic [WIDTH-1:0]          mX_q, mY_q;
  logic                      lastPixel;
  logic                      startAccept;
  logic                      beatAccept;

  assign lastPixel   = (&col_q) && (&row_q);
  assign startAccept = (state_q == IDLE) && start;
  assign beatAccept  = (state_q == OUT) && bus.m_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // MAP is left only on the ring's final stage so each pixel spends exactly one ring lap there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MAP;
      MAP:     if (bus.map_cycle_complete) state_d = CAPTURE;
      CAPTURE: state_d = OUT;
      OUT:     if (bus.m_ready) state_d = lastPixel ? DONE : MAP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    done           = (state_q == DONE);
    bus.map_enable = (state_q == MAP);
    bus.m_valid    = (state_q == OUT);
    bus.m_last     = (state_q == OUT) && lastPixel;
    bus.map_x      = originX_q + WIDTH'(col_q);
    bus.map_y      = originY_q + WIDTH'(row_q);
    bus.m_data     = mData_q;
    bus.m_x        = mX_q;
    bus.m_y        = mY_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      originX_q <= '0;
      originY_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      mData_q   <= '0;
      mX_q      <= '0;
      mY_q      <= '0;
    end else begin
      if (startAccept) begin
        originX_q <= origin_x;
        originY_q <= origin_y;
        col_q     <= '0;
        row_q     <= '0;
      end
      if (state_q == CAPTURE) begin
        mData_q <= bus.map_data;
        mX_q    <= bus.map_x;
        mY_q    <= bus.map_y;
      end
      // Counters wrap to zero after the final pixel, leaving the next pass aligned.
      if (beatAccept) begin
        col_q <= col_q + TILE_SIZE_POW2'(1);
        if (&col_q) row_q <= row_q + TILE_SIZE_POW2'(1);
      end
    end
  end

`ifdef IBIS_TILE_SEQUENCER_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                                           perf_q <= '0;
    else if (startAccept)                                   perf_q <= '0;
    else if ((state_q == OUT) && !bus.m_ready && !(&perf_q)) perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule
